// File: rtl/shrv32_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package shrv32_loader_pkg;

  // Frame decoder states.
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    COUNT,
    DATA,
    CHECK
  } loader_state_e;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Byte lengths of the multi-byte frame fields.
  localparam int unsigned ADDR_BYTES  = 4;
  localparam int unsigned COUNT_BYTES = 2;
  localparam int unsigned WORD_BYTES  = 4;

  // True when idx addresses the final byte of a field of n_bytes bytes.
  function automatic logic is_last_byte(input logic [1:0] idx, input int unsigned n_bytes);
    return idx == 2'(n_bytes - 1);
  endfunction

endpackage

// File: rtl/loader_timer.sv
// Reloadable down-counter that flags an inter-byte gap timeout.
module loader_timer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LOAD = TIMEOUT_CYCLES[W-1:0];

  logic [W-1:0] count_q, count_d;

  // Reload on activity, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (reload) begin
      count_d = LOAD;
    end else if (enable && count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == '0);

endmodule

// File: rtl/uart_boot_loader.sv
// Decodes framed load commands from the UART receive path and issues word
// writes on the CPU's memory bus while holding the CPU off.
module uart_boot_loader
  import shrv32_loader_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  input  logic        memWait,
  output logic [31:0] vaddr,
  output logic [31:0] data,
  output logic [3:0]  byteena,
  output logic        memWE,
  output logic        cpuHold,
  output logic        done,
  output logic        error,
  output logic [15:0] wordsWritten
);

  loader_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;           // byte position within the current field
  logic [23:0] sr_q, sr_d;             // previous three bytes; incoming byte is the MSB
  logic [31:0] base_q, base_d;
  logic [15:0] count_q, count_d;
  logic [15:0] words_rx_q, words_rx_d; // words fully received in this frame
  logic [7:0]  xor_q, xor_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  byteena_q, byteena_d;
  logic        we_q, we_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] words_written_q, words_written_d;

  logic [31:0] word_in;
  logic        accept;
  logic        all_rx;
  logic        timer_expired;
  logic        timer_enable;
  logic        timer_reload;

  assign timer_enable = (state_q != IDLE);
  assign timer_reload = rxValid || (state_q == IDLE);

  loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .reload (timer_reload),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // Next-state, field assembly and write-request logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    idx_d           = idx_q;
    sr_d            = sr_q;
    base_d          = base_q;
    count_d         = count_q;
    words_rx_d      = words_rx_q;
    xor_d           = xor_q;
    vaddr_d         = vaddr_q;
    data_d          = data_q;
    done_d          = 1'b0;
    error_d         = error_q;
    words_written_d = words_written_q;

    word_in = {rxData, sr_q};
    accept  = we_q && !memWait;
    all_rx  = (words_rx_q == count_q);

    // A pending write holds until the bridge takes it.
    we_d = we_q && memWait;
    if (accept && words_written_q != 16'hFFFF) begin
      words_written_d = words_written_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (rxValid && rxData == SYNC_BYTE) begin
          state_d         = ADDR;
          idx_d           = 2'd0;
          xor_d           = 8'h00;
          error_d         = 1'b0;
          words_written_d = 16'd0;
          words_rx_d      = 16'd0;
        end
      end

      ADDR: begin
        if (rxValid) begin
          sr_d  = word_in[31:8];
          xor_d = xor_q ^ rxData;
          idx_d = idx_q + 2'd1;
          if (is_last_byte(idx_q, ADDR_BYTES)) begin
            idx_d  = 2'd0;
            base_d = word_in;
            if (word_in[1:0] != 2'b00) begin
              error_d = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = COUNT;
            end
          end
        end
      end

      COUNT: begin
        if (rxValid) begin
          sr_d  = word_in[31:8];
          xor_d = xor_q ^ rxData;
          idx_d = idx_q + 2'd1;
          if (is_last_byte(idx_q, COUNT_BYTES)) begin
            idx_d   = 2'd0;
            count_d = word_in[31:16];
            state_d = (word_in[31:16] == 16'd0) ? CHECK : DATA;
          end
        end
      end

      DATA: begin
        if (rxValid && all_rx) begin
          // Checksum byte arrived while the last write is still on the bus:
          // fine if the bridge takes it on this edge, an overrun otherwise.
          state_d = IDLE;
          if (we_q && memWait) begin
            error_d = 1'b1;
            we_d    = 1'b0;
          end else if (rxData == xor_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else if (rxValid) begin
          sr_d  = word_in[31:8];
          xor_d = xor_q ^ rxData;
          idx_d = idx_q + 2'd1;
          if (is_last_byte(idx_q, WORD_BYTES)) begin
            idx_d      = 2'd0;
            words_rx_d = words_rx_q + 16'd1;
            if (we_q && memWait) begin
              // Previous word still stalled: drop it and abort the frame.
              error_d = 1'b1;
              we_d    = 1'b0;
              state_d = IDLE;
            end else begin
              we_d    = 1'b1;
              data_d  = word_in;
              vaddr_d = base_q + {14'd0, words_written_d, 2'b00};
            end
          end
        end else if (all_rx && accept) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (rxValid) begin
          state_d = IDLE;
          if (rxData == xor_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Inter-byte timeout; an arriving byte wins and a stalled write finishes first.
    if (state_q != IDLE && timer_expired && !rxValid && !(we_q && memWait)) begin
      error_d = 1'b1;
      state_d = IDLE;
    end

    byteena_d = we_d ? 4'hF : 4'h0;
    // Hold the CPU off for one extra cycle after the frame ends.
    hold_d    = (state_d != IDLE) || (state_q != IDLE);
  end

  // State and datapath registers; reset clears everything, dropping memWE at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      idx_q           <= 2'd0;
      sr_q            <= 24'd0;
      base_q          <= 32'd0;
      count_q         <= 16'd0;
      words_rx_q      <= 16'd0;
      xor_q           <= 8'h00;
      vaddr_q         <= 32'd0;
      data_q          <= 32'd0;
      byteena_q       <= 4'h0;
      we_q            <= 1'b0;
      hold_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      words_written_q <= 16'd0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      sr_q            <= sr_d;
      base_q          <= base_d;
      count_q         <= count_d;
      words_rx_q      <= words_rx_d;
      xor_q           <= xor_d;
      vaddr_q         <= vaddr_d;
      data_q          <= data_d;
      byteena_q       <= byteena_d;
      we_q            <= we_d;
      hold_q          <= hold_d;
      done_q          <= done_d;
      error_q         <= error_d;
      words_written_q <= words_written_d;
    end
  end

  assign vaddr        = vaddr_q;
  assign data         = data_q;
  assign byteena      = byteena_q;
  assign memWE        = we_q;
  assign cpuHold      = hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign wordsWritten = words_written_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench: directed frames, scoreboard of expected bus writes.
module tb_uart_boot_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        memWait;
  logic [31:0] vaddr;
  logic [31:0] data;
  logic [3:0]  byteena;
  logic        memWE;
  logic        cpuHold;
  logic        done;
  logic        error;
  logic [15:0] wordsWritten;

  uart_boot_loader #(
    .TIMEOUT_CYCLES(32'd100),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rxData      (rxData),
    .rxValid     (rxValid),
    .memWait     (memWait),
    .vaddr       (vaddr),
    .data        (data),
    .byteena     (byteena),
    .memWE       (memWE),
    .cpuHold     (cpuHold),
    .done        (done),
    .error       (error),
    .wordsWritten(wordsWritten)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_wr;
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          done_seen    = 0;
  int          exp_done     = 0;
  int          stall_cycles = 0;
  int          waited;
  logic        prev_held    = 1'b0;
  logic [31:0] prev_addr;
  logic [31:0] prev_data;
  logic [31:0] tx_words[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] wdata);
    wr_t w;
    w.addr = addr;
    w.data = wdata;
    exp_q.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clock);
    #1;
    rxData  = b;
    rxValid = 1'b1;
    @(posedge clock);
    #1;
    rxValid = 1'b0;
    repeat (gap) @(posedge clock);
  endtask

  // Sends sync, base, count, n_words of tx_words and optionally the checksum.
  task automatic send_frame(input logic [31:0] base, input logic [15:0] cnt, input int n_words,
                            input bit with_chk, input bit bad_chk, input int gap);
    logic [7:0]  chk;
    logic [31:0] w;
    chk = 8'h00;
    send_byte(8'hA5, gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(base[8*i +: 8], gap);
      chk ^= base[8*i +: 8];
    end
    for (int i = 0; i < 2; i++) begin
      send_byte(cnt[8*i +: 8], gap);
      chk ^= cnt[8*i +: 8];
    end
    for (int k = 0; k < n_words; k++) begin
      w = tx_words[k];
      for (int i = 0; i < 4; i++) begin
        send_byte(w[8*i +: 8], gap);
        chk ^= w[8*i +: 8];
      end
    end
    if (with_chk) send_byte(bad_chk ? ~chk : chk, gap);
  endtask

  // Monitor: pops the scoreboard on every accepted write, checks held writes stay stable.
  always @(negedge clock) begin
    if (!reset) begin
      if (memWE && memWait) stall_cycles++;
      if (memWE && prev_held) begin
        check("hold_addr", vaddr, prev_addr);
        check("hold_data", data, prev_data);
      end
      if (!memWE) check("byteena_idle", 32'(byteena), 32'h0);
      if (memWE && !memWait) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", vaddr, data);
        end else begin
          mon_wr = exp_q.pop_front();
          check("wr_addr", vaddr, mon_wr.addr);
          check("wr_data", data, mon_wr.data);
          check("wr_byteena", 32'(byteena), 32'hF);
        end
      end
      if (done) done_seen++;
      prev_held = memWE && memWait;
      prev_addr = vaddr;
      prev_data = data;
    end else begin
      prev_held = 1'b0;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    rxData  = 8'h00;
    rxValid = 1'b0;
    memWait = 1'b0;

    // Reset state.
    @(negedge clock);
    check("rst_vaddr", vaddr, 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_byteena", 32'(byteena), 32'h0);
    check("rst_memWE", 32'(memWE), 32'h0);
    check("rst_cpuHold", 32'(cpuHold), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_words", 32'(wordsWritten), 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);

    // Good two-word frame.
    tx_words[0] = 32'h11223344;
    tx_words[1] = 32'h55667788;
    push_write(32'h0000_1000, 32'h11223344);
    push_write(32'h0000_1004, 32'h55667788);
    exp_done++;
    send_frame(32'h0000_1000, 16'd2, 2, 1'b1, 1'b0, 2);
    @(negedge clock);
    check("a_done", 32'(done_seen), 32'(exp_done));
    check("a_words", 32'(wordsWritten), 32'd2);
    check("a_error", 32'(error), 32'h0);
    check("a_cpuHold", 32'(cpuHold), 32'h0);

    // Same frame with a corrupted checksum, then a fresh sync clears error.
    push_write(32'h0000_1000, 32'h11223344);
    push_write(32'h0000_1004, 32'h55667788);
    send_frame(32'h0000_1000, 16'd2, 2, 1'b1, 1'b1, 2);
    @(negedge clock);
    check("b_done", 32'(done_seen), 32'(exp_done));
    check("b_error", 32'(error), 32'h1);
    check("b_words", 32'(wordsWritten), 32'd2);
    send_byte(8'hA5, 0);
    @(negedge clock);
    check("b_sync_clears_error", 32'(error), 32'h0);
    check("b_sync_clears_words", 32'(wordsWritten), 32'h0);
    check("b_cpuHold_on", 32'(cpuHold), 32'h1);
    // Zero-count frame body: base 0x2000, count 0, chk 0x20.
    send_byte(8'h00, 1);
    send_byte(8'h20, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    exp_done++;
    send_byte(8'h20, 2);
    @(negedge clock);
    check("z_done", 32'(done_seen), 32'(exp_done));
    check("z_error", 32'(error), 32'h0);
    check("z_words", 32'(wordsWritten), 32'h0);

    // First write stalled for 10 cycles by memWait.
    tx_words[0] = 32'hDEADBEEF;
    tx_words[1] = 32'hCAFEF00D;
    push_write(32'h0000_3000, 32'hDEADBEEF);
    push_write(32'h0000_3004, 32'hCAFEF00D);
    exp_done++;
    stall_cycles = 0;
    memWait = 1'b1;
    fork
      send_frame(32'h0000_3000, 16'd2, 2, 1'b1, 1'b0, 5);
      begin
        waited = 0;
        while (!memWE && waited < 300) begin
          @(posedge clock);
          #1;
          waited++;
        end
        check("c_we_rise", 32'(memWE), 32'h1);
        repeat (10) @(posedge clock);
        #1 memWait = 1'b0;
      end
    join
    @(negedge clock);
    check("c_stall_cycles", 32'(stall_cycles), 32'd10);
    check("c_done", 32'(done_seen), 32'(exp_done));
    check("c_error", 32'(error), 32'h0);
    check("c_words", 32'(wordsWritten), 32'd2);

    // Overrun: bridge never takes the first write before the second word completes.
    tx_words[0] = 32'hAAAA5555;
    tx_words[1] = 32'h12345678;
    memWait = 1'b1;
    send_frame(32'h0000_4000, 16'd2, 2, 1'b0, 1'b0, 2);
    @(negedge clock);
    check("d_error", 32'(error), 32'h1);
    check("d_memWE", 32'(memWE), 32'h0);
    check("d_cpuHold", 32'(cpuHold), 32'h0);
    check("d_words", 32'(wordsWritten), 32'h0);
    memWait = 1'b0;

    // Address wrap-around.
    tx_words[0] = 32'h01020304;
    tx_words[1] = 32'hA0B0C0D0;
    push_write(32'hFFFF_FFFC, 32'h01020304);
    push_write(32'h0000_0000, 32'hA0B0C0D0);
    exp_done++;
    send_frame(32'hFFFF_FFFC, 16'd2, 2, 1'b1, 1'b0, 2);
    @(negedge clock);
    check("e_done", 32'(done_seen), 32'(exp_done));
    check("e_error", 32'(error), 32'h0);
    check("e_words", 32'(wordsWritten), 32'd2);

    // Misaligned base: error right after the fourth address byte.
    send_byte(8'hA5, 1);
    send_byte(8'h02, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 0);
    @(negedge clock);
    check("f_error_early", 32'(error), 32'h0);
    send_byte(8'h00, 0);
    @(negedge clock);
    check("f_error", 32'(error), 32'h1);
    repeat (2) @(negedge clock);
    check("f_cpuHold", 32'(cpuHold), 32'h0);
    check("f_words", 32'(wordsWritten), 32'h0);

    // Timeout: stop after the count field, error 101 cycles after the last byte.
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    send_byte(8'h50, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    send_byte(8'h00, 0);
    repeat (100) @(posedge clock);
    @(negedge clock);
    check("g_timeout_early", 32'(error), 32'h0);
    check("g_cpuHold_active", 32'(cpuHold), 32'h1);
    @(posedge clock);
    @(negedge clock);
    check("g_timeout", 32'(error), 32'h1);
    repeat (2) @(negedge clock);
    check("g_cpuHold", 32'(cpuHold), 32'h0);

    // Reset in the middle of DATA with a stalled write on the bus.
    memWait = 1'b1;
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    send_byte(8'h60, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    send_byte(8'h00, 1);
    send_byte(8'h0D, 1);
    send_byte(8'hF0, 1);
    send_byte(8'hAD, 1);
    send_byte(8'h0B, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    @(negedge clock);
    check("h_pre_reset_we", 32'(memWE), 32'h1);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("h_memWE", 32'(memWE), 32'h0);
    check("h_byteena", 32'(byteena), 32'h0);
    check("h_vaddr", vaddr, 32'h0);
    check("h_data", data, 32'h0);
    check("h_cpuHold", 32'(cpuHold), 32'h0);
    check("h_words", 32'(wordsWritten), 32'h0);
    memWait = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;

    // Recovery after reset: zero-count frame, base 0x7000, chk 0x70.
    exp_done++;
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    send_byte(8'h70, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h70, 2);
    @(negedge clock);
    check("i_done", 32'(done_seen), 32'(exp_done));
    check("i_error", 32'(error), 32'h0);

    repeat (5) @(posedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
